// File: rtl/sar_search_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sar_search_pkg
//  Description : Shared types and constants for the signed SAR search block:
//                FSM state encoding, responder verdict encodings, and a
//                helper returning the signed min/max of a given width.
//  Revision    : 1.0 - initial release
// ============================================================================
package sar_search_pkg;

    // Search controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Verdict vector is ordered {less, equal, greater}; anything not listed is
    // an inconsistent (non one-hot) response.
    localparam logic [2:0] LESS    = 3'b100;
    localparam logic [2:0] EQUAL   = 3'b010;
    localparam logic [2:0] GREATER = 3'b001;

    // Most negative (want_max=0) or most positive (want_max=1) two's-complement
    // value representable in 'width' bits.
    function automatic logic signed [31:0] signed_limit(input int width, input logic want_max);
        logic signed [31:0] mag;
        mag = 32'sd1 <<< (width - 1);
        return want_max ? (mag - 32'sd1) : -mag;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sar_midpoint.sv
`default_nettype none
// ============================================================================
//  Module      : sar_midpoint
//  Description : Combinational floor-average of two (W+1)-bit signed bounds
//                plus the empty-interval (lo > hi) flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module sar_midpoint
    import sar_search_pkg::*;
#(
    parameter int W = 4
) (
    input  logic signed [W:0] lo_i,
    input  logic signed [W:0] hi_i,
    output logic signed [W:0] mid_o,
    output logic              lo_gt_hi_o
);

    localparam int W1 = W + 1;

    // One extra bit so lo+hi never overflows before the halving shift.
    logic signed [W+1:0] w_sum;

    assign w_sum      = {lo_i[W], lo_i} + {hi_i[W], hi_i};
    // Arithmetic shift floors toward -inf; result always fits in W+1 bits.
    assign mid_o      = W1'(w_sum >>> 1);
    assign lo_gt_hi_o = (lo_i > hi_i);

endmodule
`default_nettype wire

// File: rtl/sar_search_signed.sv
`default_nettype none
// ============================================================================
//  Module      : sar_search_signed
//  Description : Binary-search initiator for an external signed comparator.
//                Drives probe values, consumes less/equal/greater verdicts,
//                and converges on the value the responder calls "equal".
//                Optional macro SAR_SEARCH_STATS_EN adds o_probe_count.
//  Revision    : 1.0 - initial release
// ============================================================================
module sar_search_signed
    import sar_search_pkg::*;
#(
    parameter int W = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    output logic                      o_busy,
    output logic [W-1:0]              o_probe,
    output logic                      o_probe_valid,
    input  logic                      i_resp_valid,
    input  logic                      i_less,
    input  logic                      i_equal,
    input  logic                      i_greater,
    output logic                      o_done,
    output logic                      o_found,
    output logic                      o_error,
`ifdef SAR_SEARCH_STATS_EN
    output logic [$clog2(W+2)-1:0]    o_probe_count,
`endif
    output logic [W-1:0]              o_result
);

    localparam int              W1      = W + 1;
    localparam logic signed [W:0] LO_INIT = W1'(signed_limit(W, 1'b0));
    localparam logic signed [W:0] HI_INIT = W1'(signed_limit(W, 1'b1));
    localparam logic signed [W:0] ONE     = W1'(1);

    state_t              state_q, state_d;
    logic signed [W:0]   lo_q, lo_d;
    logic signed [W:0]   hi_q, hi_d;
    logic signed [W:0]   mid_q, mid_d;
    logic                found_q, found_d;
    logic                error_q, error_d;
    logic [W-1:0]        result_q, result_d;

    logic                w_accept;
    logic                w_handshake;
    logic [2:0]          w_verdict;
    logic signed [W:0]   w_mid_next;
    logic                w_lo_gt_hi;

    assign w_accept    = i_start && ((state_q == IDLE) || (state_q == DONE));
    assign w_handshake = (state_q == PROBE) && i_resp_valid;
    assign w_verdict   = {i_less, i_equal, i_greater};

    // Next search bounds: full range on a new search, narrowed on a verdict.
    always_comb begin
        lo_d = lo_q;
        hi_d = hi_q;
        if (w_accept) begin
            lo_d = LO_INIT;
            hi_d = HI_INIT;
        end else if (w_handshake) begin
            if (w_verdict == LESS) begin
                lo_d = mid_q + ONE;
            end else if (w_verdict == GREATER) begin
                hi_d = mid_q - ONE;
            end
        end
    end

    // Midpoint and emptiness of the *updated* interval, so the next probe is
    // ready the cycle after a handshake.
    sar_midpoint #(
        .W (W)
    ) u_midpoint (
        .lo_i       (lo_d),
        .hi_i       (hi_d),
        .mid_o      (w_mid_next),
        .lo_gt_hi_o (w_lo_gt_hi)
    );

    // Next-state and result logic.
    always_comb begin
        state_d  = state_q;
        found_d  = found_q;
        error_d  = error_q;
        result_d = result_q;
        mid_d    = mid_q;
        case (state_q)
            IDLE, DONE: begin
                if (w_accept) begin
                    state_d = PROBE;
                    found_d = 1'b0;
                    error_d = 1'b0;
                    mid_d   = w_mid_next;
                end else begin
                    state_d = IDLE;
                end
            end
            PROBE: begin
                if (w_handshake) begin
                    case (w_verdict)
                        EQUAL: begin
                            state_d  = DONE;
                            found_d  = 1'b1;
                            result_d = mid_q[W-1:0];
                        end
                        LESS, GREATER: begin
                            // An empty interval means the responder contradicted itself.
                            if (w_lo_gt_hi) begin
                                state_d = DONE;
                                error_d = 1'b1;
                            end else begin
                                mid_d = w_mid_next;
                            end
                        end
                        default: begin
                            state_d = DONE;
                            found_d = 1'b0;
                            error_d = 1'b1;
                        end
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            mid_q    <= '0;
            found_q  <= 1'b0;
            error_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            mid_q    <= mid_d;
            found_q  <= found_d;
            error_q  <= error_d;
            result_q <= result_d;
        end
    end

    assign o_busy        = (state_q == PROBE);
    assign o_probe_valid = (state_q == PROBE);
    assign o_done        = (state_q == DONE);
    assign o_probe       = mid_q[W-1:0];
    assign o_found       = found_q;
    assign o_error       = error_q;
    assign o_result      = result_q;

`ifdef SAR_SEARCH_STATS_EN
    localparam int CNT_W = $clog2(W + 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Probe counter: restarts with each accepted search, counts handshakes.
    always_comb begin
        cnt_d = cnt_q;
        if (w_accept) begin
            cnt_d = '0;
        end else if (w_handshake) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Probe counter register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A search can never need more than W+1 probes.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (cnt_q <= CNT_W'(W + 1));
        end
    end

    assign o_probe_count = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sar_search_signed.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sar_search_signed
//  Description : Self-checking bench for sar_search_signed with a behavioural
//                signed-comparator responder and an arithmetic search model.
//                Honours SAR_SEARCH_STATS_EN for the probe counter port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_search_signed;

    localparam int W      = 4;
    localparam int MIN_V  = -(1 << (W - 1));
    localparam int MAX_V  = (1 << (W - 1)) - 1;
    localparam int BUDGET = 80;

    // Responder behaviours
    localparam int M_HONEST     = 0;
    localparam int M_BOTH_FIRST = 1;
    localparam int M_ALWAYS_LT  = 2;

    logic         clk;
    logic         i_rst;
    logic         i_start;
    logic         o_busy;
    logic [W-1:0] o_probe;
    logic         o_probe_valid;
    logic         i_resp_valid;
    logic         i_less;
    logic         i_equal;
    logic         i_greater;
    logic         o_done;
    logic         o_found;
    logic         o_error;
    logic [W-1:0] o_result;
`ifdef SAR_SEARCH_STATS_EN
    logic [$clog2(W+2)-1:0] o_probe_count;
`endif

    int n_checks;
    int n_errors;

    int exp_probes[$];
    int exp_found;
    int exp_error;
    int exp_result;

    sar_search_signed #(
        .W (W)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .o_busy        (o_busy),
        .o_probe       (o_probe),
        .o_probe_valid (o_probe_valid),
        .i_resp_valid  (i_resp_valid),
        .i_less        (i_less),
        .i_equal       (i_equal),
        .i_greater     (i_greater),
        .o_done        (o_done),
        .o_found       (o_found),
        .o_error       (o_error),
`ifdef SAR_SEARCH_STATS_EN
        .o_probe_count (o_probe_count),
`endif
        .o_result      (o_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sx(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    // Floor division by two with plain integer arithmetic.
    function automatic int floor_half(input int s);
        return (s >= 0) ? (s / 2) : -((1 - s) / 2);
    endfunction

    // Reference: the probe sequence and outcome of an ideal binary search.
    task automatic build_model(input int target, input int mode);
        int lo;
        int hi;
        int mid;
        exp_probes.delete();
        exp_found  = 0;
        exp_error  = 0;
        exp_result = 0;
        lo = MIN_V;
        hi = MAX_V;
        for (int k = 0; k < 2 * W + 4; k++) begin
            mid = floor_half(lo + hi);
            exp_probes.push_back(mid);
            if (mode == M_BOTH_FIRST) begin
                exp_error = 1;
                break;
            end
            if (mode == M_HONEST && mid == target) begin
                exp_found  = 1;
                exp_result = mid;
                break;
            end
            if (mode == M_ALWAYS_LT || mid < target) lo = mid + 1;
            else hi = mid - 1;
            if (lo > hi) begin
                exp_error = 1;
                break;
            end
        end
    endtask

    task automatic clear_resp();
        i_resp_valid = 1'b0;
        i_less       = 1'b0;
        i_equal      = 1'b0;
        i_greater    = 1'b0;
    endtask

    // Runs one search; entered and left at a falling edge.
    task automatic run_search(input int target, input int mode, input int wait_cycles,
                              input bit mid_start, input bit back_to_back);
        int cyc;
        int idx;
        int waitc;
        int p;
        build_model(target, mode);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        cyc   = 1;
        idx   = 0;
        waitc = 0;
        while (!o_done && cyc < BUDGET) begin
            clear_resp();
            if (o_probe_valid) begin
                p = sx(o_probe);
                if (idx < exp_probes.size()) check_eq("probe", p, exp_probes[idx]);
                else check_eq("probe_extra", idx, exp_probes.size() - 1);
                check_eq("busy", int'(o_busy), 1);
                if (waitc == wait_cycles) begin
                    i_resp_valid = 1'b1;
                    case (mode)
                        M_BOTH_FIRST: begin i_less = 1'b1; i_greater = 1'b1; end
                        M_ALWAYS_LT:  i_less = 1'b1;
                        default: begin
                            i_less    = (p < target);
                            i_equal   = (p == target);
                            i_greater = (p > target);
                        end
                    endcase
                    idx++;
                    waitc = 0;
                end else begin
                    waitc++;
                end
            end
            if (mid_start && cyc == 2) i_start = 1'b1;
            @(negedge clk);
            i_start = 1'b0;
            cyc++;
        end
        clear_resp();
        if (!o_done) begin
            check_eq("timeout", 0, 1);
            return;
        end
        if (wait_cycles == 0) check_eq("latency", cyc, exp_probes.size() + 1);
        check_eq("n_probes", idx, exp_probes.size());
        check_eq("found", int'(o_found), exp_found);
        check_eq("error", int'(o_error), exp_error);
        check_eq("done_busy", int'(o_busy), 0);
        check_eq("done_pvalid", int'(o_probe_valid), 0);
        if (exp_found != 0) check_eq("result", sx(o_result), exp_result);
`ifdef SAR_SEARCH_STATS_EN
        check_eq("probe_count", int'(o_probe_count), exp_probes.size());
`endif
        if (!back_to_back) begin
            @(negedge clk);
            check_eq("done_pulse", int'(o_done), 0);
            check_eq("found_held", int'(o_found), exp_found);
            check_eq("error_held", int'(o_error), exp_error);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"},   int'(o_busy), 0);
        check_eq({tag, "_pvalid"}, int'(o_probe_valid), 0);
        check_eq({tag, "_done"},   int'(o_done), 0);
        check_eq({tag, "_found"},  int'(o_found), 0);
        check_eq({tag, "_error"},  int'(o_error), 0);
        check_eq({tag, "_probe"},  int'(o_probe), 0);
        check_eq({tag, "_result"}, int'(o_result), 0);
    endtask

    // Stimulus sequence
    initial begin
        int t;
        n_checks = 0;
        n_errors = 0;
        i_rst    = 1'b1;
        i_start  = 1'b0;
        clear_resp();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        i_rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_search(5,  M_HONEST, 0, 1'b0, 1'b0);
        run_search(-8, M_HONEST, 0, 1'b0, 1'b0);
        run_search(7,  M_HONEST, 0, 1'b0, 1'b0);
        run_search(0,  M_HONEST, 3, 1'b1, 1'b0);
        run_search(0,  M_BOTH_FIRST, 0, 1'b0, 1'b0);
        run_search(0,  M_ALWAYS_LT,  0, 1'b0, 1'b0);

        // Reset during the second probe, with a verdict offered in that cycle
        build_model(5, M_HONEST);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check_eq("rst_probe1", sx(o_probe), exp_probes[0]);
        i_resp_valid = 1'b1;
        i_less       = 1'b1;
        @(negedge clk);
        check_eq("rst_probe2", sx(o_probe), exp_probes[1]);
        i_rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        i_rst = 1'b0;
        clear_resp();
        @(negedge clk);
        check_all_zero("postrst");
        run_search(-3, M_HONEST, 0, 1'b0, 1'b0);

        // Randomized honest searches, some back-to-back
        for (int n = 0; n < 24; n++) begin
            t = int'($urandom_range(MAX_V - MIN_V, 0)) + MIN_V;
            run_search(t, M_HONEST, int'($urandom_range(2, 0)), 1'b0, bit'($urandom_range(1, 0)));
        end
        run_search(MIN_V, M_HONEST, 1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
